// File: rtl/fetch_rv32_pkg.sv
// Shared RV32 fetch definitions: instruction width, PC step, default reset vector
// and the fetch FSM state encoding.
package rv32_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 32;
    localparam int unsigned PC_INCREMENT      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        HOLD    = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_rv32_pc_next.sv
// Next fetch-PC selection: redirect to a word-aligned branch target, step
// sequentially after a captured instruction, or hold.
module pc_next_rv32
    import rv32_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic [ADDRESS_WIDTH-1:0] fetch_pc_i,
    input  logic                     advance_i,
    input  logic                     branch_taken_i,
    input  logic [ADDRESS_WIDTH-1:0] branch_target_i,
    output logic [ADDRESS_WIDTH-1:0] next_pc_o
);

    // Masking the two low bits is the same as {target[AW-1:2], 2'b00}.
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(32'd3);

    always_comb begin
        next_pc_o = fetch_pc_i;
        if (branch_taken_i) begin
            next_pc_o = branch_target_i & ALIGN_MASK;
        end else if (advance_i) begin
            next_pc_o = fetch_pc_i + ADDRESS_WIDTH'(PC_INCREMENT);
        end
    end

endmodule

// File: rtl/fetch_rv32.sv
// RV32 instruction fetch: one outstanding memory read at a time, a single-entry
// output register toward decode, and branch redirect with response squashing.
module fetch_rv32
    import rv32_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    output logic                         read_enable,
    output logic [ADDRESS_WIDTH-1:0]     memory_read_address,
    input  logic [INSTRUCTION_WIDTH-1:0] memory_read_value,
    input  logic                         memory_read_valid,
    input  logic                         branch_taken,
    input  logic [ADDRESS_WIDTH-1:0]     branch_target,
    output logic [ADDRESS_WIDTH-1:0]     pc,
    output logic [INSTRUCTION_WIDTH-1:0] pc_instruction,
    output logic                         instruction_valid,
    input  logic                         decode_ready
);

    fetch_state_e                 state_q, state_d;
    logic [ADDRESS_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
    logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
    logic                         valid_q, valid_d;
    logic                         squash_q, squash_d;
    logic                         advance;

    assign advance = (state_q == WAIT) && memory_read_valid && !squash_q && !branch_taken;

    pc_next_rv32 #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_pc_next (
        .fetch_pc_i     (fetch_pc_q),
        .advance_i      (advance),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .next_pc_o      (fetch_pc_d)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        squash_d = squash_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                state_d = WAIT;
                if (branch_taken) begin
                    squash_d = 1'b1;
                end
            end
            WAIT: begin
                // A response arriving with the redirect is itself the stale one,
                // so nothing further needs squashing.
                if (branch_taken) begin
                    if (memory_read_valid) begin
                        squash_d = 1'b0;
                        state_d  = REQUEST;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (memory_read_valid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = REQUEST;
                    end else begin
                        pc_d    = fetch_pc_q;
                        instr_d = memory_read_value;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    valid_d = 1'b0;
                    state_d = REQUEST;
                end else if (decode_ready) begin
                    valid_d = 1'b0;
                    state_d = enable ? REQUEST : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            squash_q   <= squash_d;
        end
    end

    assign read_enable         = (state_q == REQUEST);
    assign memory_read_address = read_enable ? fetch_pc_q : '0;
    assign pc                  = pc_q;
    assign pc_instruction      = instr_q;
    assign instruction_valid   = valid_q;

endmodule

// File: tb/tb_fetch_rv32.sv
// Directed bench for fetch_rv32: a memory model answers each read with ~address
// after mem_lat cycles; a monitor checks every decode handshake against a queue.
module tb_fetch_rv32;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        read_enable;
    logic [31:0] memory_read_address;
    logic [31:0] memory_read_value;
    logic        memory_read_valid;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] pc_instruction;
    logic        instruction_valid;
    logic        decode_ready;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          mem_lat = 1;
    logic [63:0] exp_q[$];

    always #5 clock = ~clock;

    fetch_rv32 #(
        .ADDRESS_WIDTH(32),
        .RESET_PC     (32'h0000_0000)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .enable             (enable),
        .read_enable        (read_enable),
        .memory_read_address(memory_read_address),
        .memory_read_value  (memory_read_value),
        .memory_read_valid  (memory_read_valid),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .pc                 (pc),
        .pc_instruction     (pc_instruction),
        .instruction_valid  (instruction_valid),
        .decode_ready       (decode_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Memory model: sees the request at the falling edge, answers mem_lat cycles later.
    initial begin
        int          cnt;
        logic [31:0] addr;
        cnt               = 0;
        addr              = '0;
        memory_read_valid = 1'b0;
        memory_read_value = '0;
        forever begin
            @(negedge clock);
            memory_read_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    memory_read_valid = 1'b1;
                    memory_read_value = ~addr;
                end
            end
            if (read_enable === 1'b1) begin
                cnt  = mem_lat;
                addr = memory_read_address;
            end
        end
    end

    // Monitor: every accepted instruction must match the head of the queue.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (instruction_valid === 1'b1 && decode_ready === 1'b1 && branch_taken !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_delivery: got pc %h word %h expected none", pc, pc_instruction);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", pc, e[63:32]);
                    check("deliver_word", pc_instruction, e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        decode_ready  = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_valid", instruction_valid, 0);
        check("rst_re", read_enable, 0);
        check("rst_addr", memory_read_address, 0);
        check("rst_pc", pc, 0);
        check("rst_word", pc_instruction, 0);
        reset = 1'b0;

        // Sequential fetch, one instruction every 3 cycles
        enable = 1'b1;
        exp_q.push_back({32'h0000_0000, 32'hFFFF_FFFF});
        exp_q.push_back({32'h0000_0004, 32'hFFFF_FFFB});
        exp_q.push_back({32'h0000_0008, 32'hFFFF_FFF7});
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_re", read_enable, 1);
            check("seq_addr", memory_read_address, 32'(i * 4));
            step();
            check("seq_wait_re", read_enable, 0);
            check("seq_wait_valid", instruction_valid, 0);
            step();
            check("seq_hold_valid", instruction_valid, 1);
            if (i == 2) enable = 1'b0;
        end
        step();
        check("seq_idle_re", read_enable, 0);
        check("seq_idle_valid", instruction_valid, 0);

        // Backpressure
        decode_ready = 1'b0;
        enable       = 1'b1;
        exp_q.push_back({32'h0000_000C, 32'hFFFF_FFF3});
        step();
        check("bp_addr", memory_read_address, 32'h0000_000C);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", instruction_valid, 1);
            check("bp_pc", pc, 32'h0000_000C);
            check("bp_word", pc_instruction, 32'hFFFF_FFF3);
            check("bp_re", read_enable, 0);
            step();
        end
        decode_ready = 1'b1;
        enable       = 1'b0;
        step();
        check("bp_done_valid", instruction_valid, 0);

        // Redirect while waiting: pending word dropped, refetch at aligned target
        enable  = 1'b1;
        mem_lat = 2;
        step();
        check("br_addr0", memory_read_address, 32'h0000_0010);
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        step();
        check("br_re", read_enable, 1);
        check("br_addr", memory_read_address, 32'h0000_0100);
        check("br_valid", instruction_valid, 0);
        exp_q.push_back({32'h0000_0100, 32'hFFFF_FEFF});
        step();
        step();
        step();
        check("br_hold_valid", instruction_valid, 1);

        // Redirect coinciding with the response, landing on the top word, then wrap
        mem_lat = 1;
        step();
        check("co_addr0", memory_read_address, 32'h0000_0104);
        step();
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0;
        check("co_addr", memory_read_address, 32'hFFFF_FFFC);
        check("co_valid", instruction_valid, 0);
        exp_q.push_back({32'hFFFF_FFFC, 32'h0000_0003});
        step();
        step();
        check("co_hold_valid", instruction_valid, 1);
        step();
        check("wrap_re", read_enable, 1);
        check("wrap_addr", memory_read_address, 32'h0000_0000);
        exp_q.push_back({32'h0000_0000, 32'hFFFF_FFFF});
        step();
        enable = 1'b0;
        step();
        check("endis_valid", instruction_valid, 1);
        step();
        check("endis_idle_re", read_enable, 0);
        check("endis_idle_valid", instruction_valid, 0);
        step();
        check("endis_stay_re", read_enable, 0);

        // Reset in the middle of a wait; the late response must be ignored
        enable  = 1'b1;
        mem_lat = 3;
        step();
        check("rw_addr0", memory_read_address, 32'h0000_0004);
        step();
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check("rw_re", read_enable, 0);
        check("rw_addr", memory_read_address, 0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("rw_late_valid", instruction_valid, 0);
            step();
        end
        enable = 1'b1;
        step();
        check("rw_first_re", read_enable, 1);
        check("rw_first_addr", memory_read_address, 32'h0000_0000);
        exp_q.push_back({32'h0000_0000, 32'hFFFF_FFFF});
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (instruction_valid === 1'b1) break;
            step();
        end
        check("rw_deliver", instruction_valid, 1);
        step();
        check("rw_idle_valid", instruction_valid, 0);

        step();
        step();
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_rv32.md
FETCH_RV32 -- requirements
Module: fetch_rv32

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 32, meaning the width of every PC and address port.
REQ-003 The block SHALL have port clock  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning an asynchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  meaning new fetches are permitted while high.
REQ-006 The block SHALL have port read_enable  output  1  meaning a one-cycle instruction-memory read request.
REQ-007 The block SHALL have port memory_read_address  output  ADDRESS_WIDTH  meaning the word-aligned address of the request.
REQ-008 The block SHALL have port memory_read_value  input  32  meaning the returned instruction word.
REQ-009 The block SHALL have port memory_read_valid  input  1  meaning memory_read_value is valid this cycle.
REQ-010 The block SHALL have port branch_taken  input  1  meaning a one-cycle redirect from execute.
REQ-011 The block SHALL have port branch_target  input  ADDRESS_WIDTH  meaning the redirect address.
REQ-012 The block SHALL have port pc  output  ADDRESS_WIDTH  meaning the address of pc_instruction.
REQ-013 The block SHALL have port pc_instruction  output  32  meaning the fetched instruction presented to decode.
REQ-014 The block SHALL have port instruction_valid  output  1  meaning pc and pc_instruction are valid.
REQ-015 The block SHALL have port decode_ready  input  1  meaning decode accepts the instruction this cycle.

Function
REQ-016 The block SHALL implement the FSM states IDLE, REQUEST, WAIT and HOLD, plus an internal register fetch_pc.
REQ-017 IDLE SHALL move to REQUEST on the next edge when enable=1, and otherwise remain in IDLE.
REQ-018 REQUEST SHALL drive read_enable=1 and memory_read_address=fetch_pc for exactly one cycle, then move to WAIT.
REQ-019 In WAIT, when memory_read_valid=1 and no squash is pending, the block SHALL register pc_instruction, set pc=fetch_pc, set instruction_valid=1, set fetch_pc=fetch_pc+4, and move to HOLD.
REQ-020 Minimum latency from the REQUEST cycle to instruction_valid=1 SHALL be 2 cycles; WAIT SHALL have no timeout.
REQ-021 The handshake SHALL complete on a cycle with instruction_valid=1 and decode_ready=1; instruction_valid SHALL then clear, and HOLD SHALL move to REQUEST if enable=1, else to IDLE.
REQ-022 While in HOLD with decode_ready=0, pc, pc_instruction and instruction_valid SHALL remain stable.
REQ-023 When branch_taken=1 in any state, fetch_pc SHALL be set to {branch_target[ADDRESS_WIDTH-1:2], 2'b00}.
REQ-024 When branch_taken=1 in HOLD, instruction_valid SHALL clear and the FSM SHALL move to REQUEST; branch_taken SHALL take priority over a simultaneous decode_ready.
REQ-025 When branch_taken=1 in REQUEST or WAIT, a squash flag SHALL be set; the next memory_read_valid SHALL be discarded, the flag cleared, and the FSM SHALL move to REQUEST.
REQ-026 When branch_taken=1 and memory_read_valid=1 in the same WAIT cycle, that response SHALL be discarded.
REQ-027 fetch_pc+4 SHALL wrap modulo 2^ADDRESS_WIDTH, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-028 Deasserting enable SHALL NOT abort an outstanding request; the FSM SHALL finish it, hold until consumed, then go to IDLE.
REQ-029 memory_read_valid received in IDLE, REQUEST or HOLD SHALL be ignored.

Reset
REQ-030 While reset=1 the block SHALL hold state=IDLE, fetch_pc=RESET_PC, pc=0, pc_instruction=0, instruction_valid=0, read_enable=0, memory_read_address=0, and squash flag=0.
REQ-031 Reset asserted mid-request SHALL abandon the request, and a late memory_read_valid SHALL be ignored per REQ-029.

Structure
REQ-032 The shared package rv32_pkg SHALL hold the fetch state enum, INSTRUCTION_WIDTH=32, PC_INCREMENT=4 and the default RESET_PC.
REQ-033 The next-PC selection (sequential, redirect, hold) SHALL be one sub-module, pc_next_rv32; the FSM and registers SHALL stay in fetch_rv32.

Verification
REQ-034 Sequential fetch: RESET_PC=0, memory returns after 1 cycle, decode_ready=1 -> pc 0x0, 0x4, 0x8 with matching words, one instruction every 3 cycles.
REQ-035 Backpressure: decode_ready=0 for 5 cycles in HOLD -> pc and pc_instruction stable, no read_enable pulses.
REQ-036 Redirect in WAIT: branch_taken=1 with target 0x103 -> the pending word is discarded, and the next request and pc are 0x100.
REQ-037 Wrap: fetch from 0xFFFF_FFFC -> the next request address is 0x0000_0000.
REQ-038 Reset mid-WAIT, then memory_read_valid=1 -> instruction_valid stays 0, the first request after reset is at RESET_PC.
REQ-039 enable dropped during WAIT -> the instruction is delivered once, then the FSM is in IDLE with read_enable=0.
